// File: rtl/io_input_port.sv
// io_input_port: two-flop synchronised, debounced switch groups and pushbutton,
// with sticky change/press status and a registered CPU read port.
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  sw0,
  input  logic [3:0]  sw1,
  input  logic        key_n,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic [3:0]  in_port0,
  output logic [3:0]  in_port1,
  output logic        key_press
);
  logic        upd0, upd1, updk, key_st, press, clr;
  logic        chg0, chg1, kp_pend;
  logic [7:0]  key_count;
  logic [31:0] status, sel_word;

  io_debounce #(.W(4), .D(DEBOUNCE_CYCLES), .CW(CNT_W), .INIT(4'h0)) u_sw0 (
    .clock(clock), .resetn(resetn), .raw(sw0), .stable(in_port0), .upd(upd0)
  );
  io_debounce #(.W(4), .D(DEBOUNCE_CYCLES), .CW(CNT_W), .INIT(4'h0)) u_sw1 (
    .clock(clock), .resetn(resetn), .raw(sw1), .stable(in_port1), .upd(upd1)
  );
  io_debounce #(.W(1), .D(DEBOUNCE_CYCLES), .CW(CNT_W), .INIT(1'b1)) u_key (
    .clock(clock), .resetn(resetn), .raw(key_n), .stable(key_st), .upd(updk)
  );

  // a key update while the stable level is 1 is a 1->0 press; releases are ignored
  assign press  = updk & key_st;
  assign clr    = rd_en & (rd_sel == 2'd2);
  assign status = {16'h0, key_count, 5'h0, kp_pend, chg1, chg0};

  always_comb
    sel_word = rd_sel == 2'd0 ? {28'h0, in_port0} :
               rd_sel == 2'd1 ? {28'h0, in_port1} :
               rd_sel == 2'd2 ? status : 32'h0;

  // set events beat the read-clear landing on the same edge
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      key_press <= 1'b0;
      key_count <= 8'h0;
      chg0      <= 1'b0;
      chg1      <= 1'b0;
      kp_pend   <= 1'b0;
      rd_data   <= 32'h0;
    end else begin
      key_press <= press;
      key_count <= key_count + {7'h0, press};
      chg0      <= upd0 | (chg0 & ~clr);
      chg1      <= upd1 | (chg1 & ~clr);
      kp_pend   <= press | (kp_pend & ~clr);
      if (rd_en) rd_data <= sel_word;
    end
endmodule

// io_debounce: 2-flop synchroniser plus a candidate/counter filter; upd flags
// the edge on which stable takes a new value.
module io_debounce #(
  parameter int             W    = 4,
  parameter int             D    = 4,
  parameter int             CW   = 3,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         upd
);
  logic [W-1:0]  s1, s2, cand;
  logic [CW-1:0] cnt;
  logic          hit;

  // the candidate has been seen on D consecutive synchronised samples
  assign hit = (s2 == cand) && (cnt >= CW'(D - 2));
  assign upd = hit && (cand != stable);

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1     <= INIT;
      s2     <= INIT;
      cand   <= INIT;
      stable <= INIT;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CW'(D - 1)) cnt <= cnt + CW'(1);
      if (hit) stable <= cand;
    end
endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed scenarios plus random stimulus against a
// history-window reference model of the input port.
module tb_io_input_port;
  localparam int DB = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  sw0 = 4'h0, sw1 = 4'h0;
  logic        key_n = 1'b1, rd_en = 1'b0;
  logic [1:0]  rd_sel = 2'd0;
  logic [31:0] rd_data;
  logic [3:0]  in_port0, in_port1;
  logic        key_press;

  int n_chk = 0, n_fail = 0;

  io_input_port #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock(clock), .resetn(resetn), .sw0(sw0), .sw1(sw1), .key_n(key_n),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
    .in_port0(in_port0), .in_port1(in_port1), .key_press(key_press)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: raw samples per edge; a channel accepts a value once the
  // D samples that have passed the 2-flop synchroniser all agree on it.
  logic [8:0]  hist[$];
  logic [3:0]  m_in0 = 4'h0, m_in1 = 4'h0, n0, n1;
  logic        m_key = 1'b1, nk, m_press = 1'b0, e0, e1, ek, m_clr;
  logic        m_c0 = 1'b0, m_c1 = 1'b0, m_kp = 1'b0;
  logic [7:0]  m_cnt = 8'h0;
  logic [31:0] m_rd = 32'h0, m_st;

  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      hist = {};
      m_in0 = 4'h0; m_in1 = 4'h0; m_key = 1'b1; m_press = 1'b0;
      m_c0 = 1'b0; m_c1 = 1'b0; m_kp = 1'b0; m_cnt = 8'h0; m_rd = 32'h0;
    end else begin
      m_st  = {16'h0, m_cnt, 5'h0, m_kp, m_c1, m_c0};
      m_clr = rd_en && rd_sel == 2'd2;
      if (rd_en)
        case (rd_sel)
          2'd0: m_rd = {28'h0, m_in0};
          2'd1: m_rd = {28'h0, m_in1};
          2'd2: m_rd = m_st;
          default: m_rd = 32'h0;
        endcase
      hist.push_back({key_n, sw1, sw0});
      if (hist.size() > DB + 2) void'(hist.pop_front());
      n0 = m_in0; n1 = m_in1; nk = m_key;
      if (hist.size() == DB + 2) begin
        e0 = 1'b1; e1 = 1'b1; ek = 1'b1;
        for (int i = 1; i < DB; i++) begin
          e0 &= hist[i][3:0] == hist[0][3:0];
          e1 &= hist[i][7:4] == hist[0][7:4];
          ek &= hist[i][8] == hist[0][8];
        end
        if (e0) n0 = hist[0][3:0];
        if (e1) n1 = hist[0][7:4];
        if (ek) nk = hist[0][8];
      end
      m_press = m_key && !nk;
      m_c0 = (n0 != m_in0) || (m_c0 && !m_clr);
      m_c1 = (n1 != m_in1) || (m_c1 && !m_clr);
      m_kp = m_press || (m_kp && !m_clr);
      if (m_press) m_cnt = m_cnt + 8'd1;
      m_in0 = n0; m_in1 = n1; m_key = nk;
    end
  end

  initial forever begin
    @(negedge clock);
    chk("cmp_in_port0", in_port0, m_in0);
    chk("cmp_in_port1", in_port1, m_in1);
    chk("cmp_key_press", key_press, m_press);
    chk("cmp_rd_data", rd_data, m_rd);
  end

  int pulses;
  logic seen9;

  initial begin
    cyc(2);
    chk("reset_in_port0", in_port0, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_key_press", key_press, 0);
    resetn = 1'b1;
    cyc(8);
    // 1: single switch change qualifies at edge k+1+D
    sw0 = 4'h5;
    cyc(5);
    chk("t1_early", in_port0, 0);
    cyc(1);
    chk("t1_in_port0", in_port0, 5);
    chk("t1_model", m_in0, 5);
    chk("t1_in_port1", in_port1, 0);
    // 4: status read returns chg0 and clears it
    rd_en = 1'b1; rd_sel = 2'd2;
    cyc(1);
    chk("t4_status", rd_data, 32'h1);
    cyc(1);
    chk("t4_reread", rd_data, 32'h0);
    rd_en = 1'b0;
    cyc(3);
    chk("t4_hold", rd_data, 32'h0);
    // 5: qualification on the same edge as a status read
    sw0 = 4'h6;
    cyc(5);
    rd_en = 1'b1; rd_sel = 2'd2;
    cyc(1);
    chk("t5_first", rd_data, 32'h0);
    chk("t5_in_port0", in_port0, 6);
    cyc(1);
    chk("t5_second", rd_data, 32'h1);
    rd_sel = 2'd0;
    cyc(1);
    chk("rd_sel0", rd_data, 32'h6);
    rd_sel = 2'd3;
    cyc(1);
    chk("rd_sel3", rd_data, 32'h0);
    rd_en = 1'b0;
    // 2: bouncing switch never qualifies the glitch value
    seen9 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sw1 = (i % 2 == 0) ? 4'h9 : 4'h0;
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        if (in_port1 == 4'h9) seen9 = 1'b1;
      end
    end
    chk("t2_no_glitch", seen9, 0);
    sw1 = 4'h3;
    cyc(5);
    chk("t2_early", in_port1, 0);
    cyc(1);
    chk("t2_in_port1", in_port1, 3);
    // 3: three presses, three single pulses
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      key_n = 1'b0;
      for (int j = 0; j < 10; j++) begin cyc(1); pulses += key_press; end
      key_n = 1'b1;
      for (int j = 0; j < 10; j++) begin cyc(1); pulses += key_press; end
    end
    chk("t3_pulses", pulses, 3);
    chk("t3_model_cnt", m_cnt, 3);
    rd_en = 1'b1; rd_sel = 2'd2;
    cyc(1);
    chk("t3_status", rd_data, 32'h0000_0306);
    rd_en = 1'b0;
    // 6: key_count wraps after 256 presses
    for (int p = 0; p < 253; p++) begin
      key_n = 1'b0; cyc(7);
      key_n = 1'b1; cyc(7);
    end
    rd_en = 1'b1; rd_sel = 2'd2;
    cyc(1);
    chk("t6_wrap", rd_data, 32'h0000_0004);
    rd_en = 1'b0;
    // 6: asynchronous reset mid-debounce, then re-qualification
    sw0 = 4'h7;
    cyc(3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_in_port0", in_port0, 0);
    chk("t6_rst_in_port1", in_port1, 0);
    chk("t6_rst_rd_data", rd_data, 0);
    chk("t6_rst_key_press", key_press, 0);
    cyc(2);
    resetn = 1'b1;
    cyc(5);
    chk("t6_early", in_port0, 0);
    cyc(1);
    chk("t6_requal", in_port0, 7);
    // random phase checked cycle by cycle against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) == 0) sw0 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) sw1 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) key_n = ~key_n;
      rd_en  = $urandom_range(0, 2) == 0;
      rd_sel = 2'($urandom);
      if (c == 1200) begin
        #3 resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
      end else cyc(1);
    end
    rd_en = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
